ariane_mem2axi: RTL



---
 rtl/ariane_mem2axi.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/ariane_mem2axi.sv
// Single-outstanding bridge from a req/gnt memory port to an AXI4 master.
// Every transaction is one beat (len 0, INCR) with a fixed ID.
module ariane_mem2axi #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned AXI_ID         = 0
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  // memory port
  input  logic                        mem_req_i,
  output logic                        mem_gnt_o,
  input  logic [AXI_ADDR_WIDTH-1:0]   mem_addr_i,
  input  logic                        mem_we_i,
  input  logic [AXI_DATA_WIDTH-1:0]   mem_wdata_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] mem_strb_i,
  output logic                        mem_rvalid_o,
  output logic [AXI_DATA_WIDTH-1:0]   mem_rdata_o,
  output logic                        mem_err_o,
  // AW
  output logic                        aw_valid_o,
  input  logic                        aw_ready_i,
  output logic [AXI_ADDR_WIDTH-1:0]   aw_addr_o,
  output logic [AXI_ID_WIDTH-1:0]     aw_id_o,
  output logic [2:0]                  aw_size_o,
  output logic [7:0]                  aw_len_o,
  output logic [1:0]                  aw_burst_o,
  // W
  output logic                        w_valid_o,
  input  logic                        w_ready_i,
  output logic [AXI_DATA_WIDTH-1:0]   w_data_o,
  output logic [AXI_DATA_WIDTH/8-1:0] w_strb_o,
  output logic                        w_last_o,
  // B
  input  logic                        b_valid_i,
  output logic                        b_ready_o,
  input  logic [1:0]                  b_resp_i,
  // AR
  output logic                        ar_valid_o,
  input  logic                        ar_ready_i,
  output logic [AXI_ADDR_WIDTH-1:0]   ar_addr_o,
  output logic [AXI_ID_WIDTH-1:0]     ar_id_o,
  output logic [2:0]                  ar_size_o,
  output logic [7:0]                  ar_len_o,
  output logic [1:0]                  ar_burst_o,
  // R
  input  logic                        r_valid_i,
  output logic                        r_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0]   r_data_i,
  input  logic [1:0]                  r_resp_i
);

  localparam int unsigned SW  = AXI_DATA_WIDTH / 8;
  localparam int unsigned OFF = $clog2(SW);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WAIT_B,
    RD,
    WAIT_R
  } state_e;

  state_e                      state_q;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [AXI_DATA_WIDTH-1:0]   wdata_q;
  logic [SW-1:0]               strb_q;
  logic                        aw_valid_q, w_valid_q, ar_valid_q;
  logic                        b_ready_q, r_ready_q;
  logic                        rvalid_q, err_q;
  logic [AXI_DATA_WIDTH-1:0]   rdata_q;

  logic [AXI_ADDR_WIDTH-1:0]   addr_aligned;
  logic                        aw_done, w_done;

  assign addr_aligned = mem_addr_i & ~AXI_ADDR_WIDTH'(SW - 1);

  // A channel is done once its valid has dropped or it handshakes this cycle.
  assign aw_done = ~aw_valid_q | aw_ready_i;
  assign w_done  = ~w_valid_q  | w_ready_i;

  assign mem_gnt_o = (state_q == IDLE) & mem_req_i & ~rst_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      strb_q     <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      b_ready_q  <= 1'b0;
      r_ready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      rvalid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (mem_req_i) begin
            addr_q  <= addr_aligned;
            wdata_q <= mem_wdata_i;
            strb_q  <= mem_strb_i;
            if (mem_we_i) begin
              aw_valid_q <= 1'b1;
              w_valid_q  <= 1'b1;
              state_q    <= WR;
            end else begin
              ar_valid_q <= 1'b1;
              state_q    <= RD;
            end
          end
        end
        WR: begin
          if (aw_valid_q && aw_ready_i) aw_valid_q <= 1'b0;
          if (w_valid_q && w_ready_i)   w_valid_q  <= 1'b0;
          if (aw_done && w_done) begin
            b_ready_q <= 1'b1;
            state_q   <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (b_valid_i) begin
            b_ready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            err_q     <= (b_resp_i != 2'b00);
            rdata_q   <= '0;
            state_q   <= IDLE;
          end
        end
        RD: begin
          if (ar_ready_i) begin
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
            state_q    <= WAIT_R;
          end
        end
        WAIT_R: begin
          if (r_valid_i) begin
            r_ready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            err_q     <= (r_resp_i != 2'b00);
            rdata_q   <= r_data_i;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_rvalid_o = rvalid_q;
  assign mem_rdata_o  = rdata_q;
  assign mem_err_o    = err_q;

  assign aw_valid_o = aw_valid_q;
  assign aw_addr_o  = addr_q;
  assign aw_id_o    = AXI_ID_WIDTH'(AXI_ID);
  assign aw_size_o  = 3'(OFF);
  assign aw_len_o   = 8'd0;
  assign aw_burst_o = 2'b01;

  assign w_valid_o  = w_valid_q;
  assign w_data_o   = wdata_q;
  assign w_strb_o   = strb_q;
  assign w_last_o   = 1'b1;

  assign b_ready_o  = b_ready_q;

  assign ar_valid_o = ar_valid_q;
  assign ar_addr_o  = addr_q;
  assign ar_id_o    = AXI_ID_WIDTH'(AXI_ID);
  assign ar_size_o  = 3'(OFF);
  assign ar_len_o   = 8'd0;
  assign ar_burst_o = 2'b01;

  assign r_ready_o  = r_ready_q;

endmodule
